jedro_1_instr_rx: RTL and testbench
===================================

// Module: jedro_1_instr_rx
// PURPOSE
//  Receiving end of the fetch->decode handshake: accepts {instr,addr} from the IFU on valid/ready,
//  buffers up to 2 words (main + skid register), presents them to decode on a second valid/ready pair.
//  Registered ready_o breaks the comb path from downstream stall back into the IFU; flush_i drops work on jumps.
// PARAMETERS
//  CNT_WIDTH  32  width of retired-transfer counter xfer_cnt_o (wraps modulo 2^CNT_WIDTH)
// PORTS
//  clk_i       in   1           clock, all flops on rising edge
//  rst_i       in   1           reset, asynchronous, active-high
//  instr_i     in   DATA_WIDTH  instruction from IFU
//  addr_i      in   DATA_WIDTH  PC of instr_i
//  valid_i     in   1           IFU word valid; may drop without a transfer (jump/stall-in-stall)
//  ready_o     out  1           receiver can accept; driven from state flop only
//  flush_i     in   1           discard all buffered words (taken jump / exception)
//  instr_o     out  DATA_WIDTH  instruction to decode
//  addr_o      out  DATA_WIDTH  PC of instr_o
//  valid_o     out  1           instr_o/addr_o valid
//  ready_i     in   1           decode accepts
//  illegal_o   out  1           encoding/alignment fault on current output word (see CONFIGURATION)
//  occ_o       out  2           words held: 0,1,2
//  xfer_cnt_o  out  CNT_WIDTH   count of downstream transfers
// BEHAVIOUR
//  Transfer in: valid_i&ready_o at posedge. Transfer out: valid_o&ready_i at posedge.
//  Reset (any time, mid-transfer included): state EMPTY, valid_o=0, ready_o=1, instr_o=NOP_INSTR,
//   addr_o=0, illegal_o=0, occ_o=0, xfer_cnt_o=0; skid contents don't care.
//  States (state_t): EMPTY (main empty), BUSY (main full), FULL (main+skid full). ready_o=(state!=FULL).
//  EMPTY: in -> BUSY, main<=in.
//  BUSY : in&out -> BUSY, main<=in; in only -> FULL, skid<=in; out only -> EMPTY; none -> BUSY, hold.
//  FULL : out -> BUSY, main<=skid; else hold. No input accepted (ready_o=0).
//  flush_i has priority: next state EMPTY, any in/out transfer in that cycle is discarded, xfer_cnt_o
//   not incremented, ready_o=1 next cycle.
//  Latency: word accepted at edge N appears on instr_o with valid_o=1 after edge N (1 cycle), in order.
//  valid_o=(state!=EMPTY). When valid_o=0, instr_o=NOP_INSTR, addr_o=0 (forced).
//  Throughput 1 word/cycle while ready_i=1; downstream stall of 1 cycle costs no IFU stall.
//  ready_i high with valid_o low: no effect. valid_i dropping with ready_o high: no effect.
//  occ_o = 0/1/2 for EMPTY/BUSY/FULL. xfer_cnt_o +1 per non-flushed out transfer, wraps to 0.
//  No data is ever overwritten: skid only written in BUSY, main only written when emptied same cycle.
// CONFIGURATION
//  Macro JEDRO_1_ILLEGAL_CHECK_EN:
//   defined: illegal_o=valid_o & (instr_o[1:0]!=2'b11 | addr_o[1:0]!=2'b00), computed at load time
//    and stored as a flag bit with each buffered word (no comb path from data to illegal_o);
//    word still passes through normally, decode decides the trap.
//   undefined: illegal_o tied 0, no flag storage; all else identical.
// STRUCTURE
//  jedro_1_defines (shared package): DATA_WIDTH, NOP_INSTR, state_t enum {EMPTY,BUSY,FULL},
//   ifetch_word_t struct {instr, addr, illegal}.
//  Sub-module jedro_1_instr_reg: one ifetch_word_t register with load enable and async reset to
//   {NOP_INSTR,0,0}; instantiated twice (main, skid). FSM, counter, muxing in top.
// TESTING
//  1 Reset: rst_i=1 mid-stream -> next edge valid_o=0, ready_o=1, occ_o=0, instr_o=0x00000013, xfer_cnt_o=0.
//  2 Streaming: ready_i=1, valid_i=1, instr 0x00100093@0x80000000.. 4 words -> out in order, 1-cycle
//    latency, ready_o never low, xfer_cnt_o=4.
//  3 Backpressure: ready_i=0 for 3 cycles while valid_i=1 -> occ_o 1->2, ready_o=0 after 2nd accept,
//    no loss/duplication; ready_i=1 -> skid word follows main, occ_o back to 1.
//  4 Flush: FULL, flush_i=1 with valid_i=1 -> next cycle EMPTY, valid_o=0, ready_o=1, xfer_cnt_o unchanged;
//    next accepted word (jump target 0x80000100) is first output.
//  5 Illegal (macro on): instr 0x00000000 -> illegal_o=1 with that word; addr 0x80000002 -> illegal_o=1;
//    macro off -> illegal_o=0 always.
//  6 Counter wrap: CNT_WIDTH=4, 17 out transfers -> xfer_cnt_o=1.

Source files
------------

// File: rtl/jedro_1_defines.sv
// ---------------------------------------------------------------------------
// jedro_1_defines
//   Shared definitions for the fetch->decode receive buffer.
//   DATA_WIDTH    : instruction / address width
//   NOP_INSTR     : word presented on instr_o whenever nothing is valid
//   state_t       : buffer state (EMPTY / BUSY / FULL)
//   ifetch_word_t : one buffered word {instr, addr, illegal}
//   Optional feature macro: JEDRO_1_ILLEGAL_CHECK_EN (see jedro_1_instr_rx).
// ---------------------------------------------------------------------------
package jedro_1_defines;

   localparam int DATA_WIDTH = 32;
   localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] instr;
      logic [DATA_WIDTH-1:0] addr;
      logic                  illegal;
   } ifetch_word_t;

   localparam ifetch_word_t RESET_WORD = '{instr: NOP_INSTR, addr: '0, illegal: 1'b0};

   // Non-compressed encoding must end in 2'b11 and the PC must be word aligned.
   function automatic logic word_is_illegal(input logic [DATA_WIDTH-1:0] instr,
                                            input logic [DATA_WIDTH-1:0] addr);
      return (instr[1:0] != 2'b11) || (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/jedro_1_instr_reg.sv
// ---------------------------------------------------------------------------
// jedro_1_instr_reg
//   One ifetch_word_t register with load enable. Async reset to
//   {NOP_INSTR, 0, 0}.
//   Ports:
//     i_clk   clock (rising edge)
//     i_rst   async reset, active high
//     i_load  load i_word on the next rising edge
//     i_word  word to store
//     o_word  stored word
// ---------------------------------------------------------------------------
module jedro_1_instr_reg
   import jedro_1_defines::*;
(
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  ifetch_word_t i_word,
   output ifetch_word_t o_word
);

   ifetch_word_t r_word;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_word <= RESET_WORD;
      end else if (i_load) begin
         r_word <= i_word;
      end
   end

   assign o_word = r_word;

endmodule

// File: rtl/jedro_1_instr_rx.sv
// ---------------------------------------------------------------------------
// jedro_1_instr_rx
//   Receiving end of the fetch->decode handshake. Accepts {instr,addr} from
//   the IFU, buffers up to two words (main + skid) and presents them to
//   decode. ready_o comes straight from the state flop, so a decode stall
//   never reaches the IFU combinationally. flush_i drops all buffered work.
//
//   Handshake: a transfer happens on a rising edge where valid and ready of
//   that pair are both high. valid may drop without a transfer; the side
//   raising valid holds the data stable until it is taken or withdrawn.
//
//   Ports:
//     clk_i, rst_i          clock, async active-high reset
//     instr_i, addr_i       word from IFU
//     valid_i / ready_o     IFU-side handshake
//     flush_i               discard all buffered words (highest priority)
//     instr_o, addr_o       word to decode (NOP / 0 when not valid)
//     valid_o / ready_i     decode-side handshake
//     illegal_o             fault flag for the current output word
//     occ_o                 words held (0..2)
//     xfer_cnt_o            count of non-flushed decode transfers (wraps)
//
//   Macro JEDRO_1_ILLEGAL_CHECK_EN: when defined, each word gets an illegal
//   flag computed at load time and stored alongside it; when undefined,
//   illegal_o is tied low.
// ---------------------------------------------------------------------------
module jedro_1_instr_rx
   import jedro_1_defines::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] instr_i,
   input  logic [DATA_WIDTH-1:0] addr_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic                  flush_i,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [DATA_WIDTH-1:0] addr_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  illegal_o,
   output logic [1:0]            occ_o,
   output logic [CNT_WIDTH-1:0]  xfer_cnt_o
);

   state_t               r_state;
   state_t               w_next;
   logic                 w_in_xfer;
   logic                 w_out_xfer;
   logic                 w_main_ld;
   logic                 w_main_from_skid;
   logic                 w_skid_ld;
   ifetch_word_t         w_in_word;
   ifetch_word_t         w_main_d;
   ifetch_word_t         w_main_q;
   ifetch_word_t         w_skid_q;
   logic [CNT_WIDTH-1:0] r_xfer_cnt;

   assign w_in_xfer  = valid_i & ready_o;
   assign w_out_xfer = valid_o & ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_next;
      end
   end

   // Main is only loaded when it is empty or emptied in the same cycle;
   // skid is only loaded from BUSY, so no word is ever overwritten.
   always_comb begin
      w_next           = r_state;
      w_main_ld        = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_ld        = 1'b0;
      if (flush_i) begin
         w_next = EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_in_xfer) begin
                  w_next    = BUSY;
                  w_main_ld = 1'b1;
               end
            end
            BUSY: begin
               if (w_in_xfer && w_out_xfer) begin
                  w_main_ld = 1'b1;
               end else if (w_in_xfer) begin
                  w_next    = FULL;
                  w_skid_ld = 1'b1;
               end else if (w_out_xfer) begin
                  w_next = EMPTY;
               end
            end
            FULL: begin
               if (w_out_xfer) begin
                  w_next           = BUSY;
                  w_main_ld        = 1'b1;
                  w_main_from_skid = 1'b1;
               end
            end
            default: begin
               w_next = EMPTY;
            end
         endcase
      end
   end

   always_comb begin
      w_in_word.instr = instr_i;
      w_in_word.addr  = addr_i;
`ifdef JEDRO_1_ILLEGAL_CHECK_EN
      w_in_word.illegal = word_is_illegal(instr_i, addr_i);
`else
      w_in_word.illegal = 1'b0;
`endif
   end

   assign w_main_d = w_main_from_skid ? w_skid_q : w_in_word;

   jedro_1_instr_reg u_main (
      .i_clk  (clk_i),
      .i_rst  (rst_i),
      .i_load (w_main_ld),
      .i_word (w_main_d),
      .o_word (w_main_q)
   );

   jedro_1_instr_reg u_skid (
      .i_clk  (clk_i),
      .i_rst  (rst_i),
      .i_load (w_skid_ld),
      .i_word (w_in_word),
      .o_word (w_skid_q)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_xfer_cnt <= '0;
      end else if (!flush_i && w_out_xfer) begin
         r_xfer_cnt <= r_xfer_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   assign valid_o    = (r_state != EMPTY);
   assign ready_o    = (r_state != FULL);
   assign instr_o    = valid_o ? w_main_q.instr : NOP_INSTR;
   assign addr_o     = valid_o ? w_main_q.addr  : '0;
   assign xfer_cnt_o = r_xfer_cnt;

   always_comb begin
      case (r_state)
         BUSY:    occ_o = 2'd1;
         FULL:    occ_o = 2'd2;
         default: occ_o = 2'd0;
      endcase
   end

`ifdef JEDRO_1_ILLEGAL_CHECK_EN
   assign illegal_o = valid_o & w_main_q.illegal;
`else
   logic w_unused_flag;
   assign w_unused_flag = w_main_q.illegal;
   assign illegal_o     = 1'b0;
`endif

endmodule

// File: tb/tb_jedro_1_instr_rx.sv
module tb_jedro_1_instr_rx;

   localparam int CW = 4;
   localparam int OW = 1 + 1 + 2 + 1 + CW + 32 + 32;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [31:0]   instr_i = '0;
   logic [31:0]   addr_i = '0;
   logic          valid_i = 1'b0;
   logic          ready_o;
   logic          flush_i = 1'b0;
   logic [31:0]   instr_o;
   logic [31:0]   addr_o;
   logic          valid_o;
   logic          ready_i = 1'b0;
   logic          illegal_o;
   logic [1:0]    occ_o;
   logic [CW-1:0] xfer_cnt_o;

   int total = 0;
   int bad   = 0;

   jedro_1_instr_rx #(.CNT_WIDTH(CW)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .instr_i    (instr_i),
      .addr_i     (addr_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .flush_i    (flush_i),
      .instr_o    (instr_o),
      .addr_o     (addr_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .illegal_o  (illegal_o),
      .occ_o      (occ_o),
      .xfer_cnt_o (xfer_cnt_o)
   );

   // clock / reset
   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit expired");
      $fatal(1, "watchdog");
   end

   // reference model: FIFO of at most two words plus a transfer count
   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
   } mword_t;

   mword_t      mq[$];
   int unsigned mcnt = 0;

   logic [OW-1:0] obs;
   assign obs = {valid_o, ready_o, occ_o, illegal_o, xfer_cnt_o, instr_o, addr_o};

   function automatic logic [OW-1:0] exp_vec();
      logic          v;
      logic          r;
      logic [1:0]    o;
      logic          ill;
      logic [CW-1:0] c;
      logic [31:0]   ins;
      logic [31:0]   ad;
      v   = (mq.size() > 0);
      r   = (mq.size() < 2);
      o   = 2'(mq.size());
      c   = CW'(mcnt % (1 << CW));
      ins = v ? mq[0].instr : 32'h0000_0013;
      ad  = v ? mq[0].addr  : 32'h0;
      ill = 1'b0;
`ifdef JEDRO_1_ILLEGAL_CHECK_EN
      if (v) ill = (ins[1:0] != 2'b11) || (ad[1:0] != 2'b00);
`endif
      return {v, r, o, ill, c, ins, ad};
   endfunction

   // driver: apply inputs, take one edge, advance the model, settle
   task automatic step(input logic vi, input logic [31:0] ins, input logic [31:0] ad,
                       input logic ri, input logic fl, output logic acc);
      logic rdy;
      logic have;
      valid_i = vi;
      instr_i = ins;
      addr_i  = ad;
      ready_i = ri;
      flush_i = fl;
      rdy  = (mq.size() < 2);
      have = (mq.size() > 0);
      acc  = vi && rdy && !fl;
      @(posedge clk_i);
      if (fl) begin
         mq.delete();
      end else begin
         if (have && ri) begin
            void'(mq.pop_front());
            mcnt++;
         end
         if (vi && rdy) mq.push_back('{ins, ad});
      end
      #1;
   endtask

   task automatic do_reset();
      valid_i = 1'b0;
      ready_i = 1'b0;
      flush_i = 1'b0;
      rst_i   = 1'b1;
      mq.delete();
      mcnt = 0;
      #3;
      rst_i = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      logic acc;
      // initial reset state
      if (obs !== exp_vec()) begin
         bad++;
         $display("FAIL reset_init got=%h exp=%h", obs, exp_vec());
      end
      total++;
      rst_i = 1'b0;
      // fill mid-stream, then assert reset between edges
      step(1'b1, 32'h0010_0093, 32'h8000_0000, 1'b1, 1'b0, acc);
      step(1'b1, 32'h0020_0113, 32'h8000_0004, 1'b1, 1'b0, acc);
      step(1'b1, 32'h0030_0193, 32'h8000_0008, 1'b0, 1'b0, acc);
      #2;
      rst_i = 1'b1;
      mq.delete();
      mcnt = 0;
      #1;
      if (obs !== exp_vec()) begin
         bad++;
         $display("FAIL reset_async got=%h exp=%h", obs, exp_vec());
      end
      total++;
      if (instr_o !== 32'h0000_0013 || xfer_cnt_o !== '0 || ready_o !== 1'b1) begin
         bad++;
         $display("FAIL reset_fields instr=%h cnt=%0d rdy=%b exp 00000013/0/1", instr_o, xfer_cnt_o, ready_o);
      end
      total++;
      @(posedge clk_i);
      #2;
      rst_i = 1'b0;
      #1;
   endtask

   task automatic test_streaming();
      logic acc;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         step(k < 4, 32'h0010_0093 + 32'(k << 7), 32'h8000_0000 + 32'(4 * k), 1'b1, 1'b0, acc);
         if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL stream k=%0d got=%h exp=%h", k, obs, exp_vec());
         end
         total++;
      end
      if (xfer_cnt_o !== CW'(4) || valid_o !== 1'b0) begin
         bad++;
         $display("FAIL stream_count cnt=%0d valid=%b exp 4/0", xfer_cnt_o, valid_o);
      end
      total++;
   endtask

   task automatic test_backpressure();
      logic        acc;
      int          n = 0;
      logic [31:0] a = 32'h8000_0040;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         step(n < 4, 32'h0000_0013 + 32'(n << 20), a, (k >= 3), 1'b0, acc);
         if (acc) begin
            n++;
            a = a + 4;
         end
         if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL backpressure k=%0d got=%h exp=%h", k, obs, exp_vec());
         end
         total++;
      end
   endtask

   task automatic test_flush();
      logic acc;
      do_reset();
      step(1'b1, 32'h0000_0093, 32'h8000_0010, 1'b0, 1'b0, acc);
      step(1'b1, 32'h0000_0113, 32'h8000_0014, 1'b0, 1'b0, acc);
      if (occ_o !== 2'd2 || ready_o !== 1'b0) begin
         bad++;
         $display("FAIL flush_full occ=%0d rdy=%b exp 2/0", occ_o, ready_o);
      end
      total++;
      step(1'b1, 32'h0000_0193, 32'h8000_0018, 1'b1, 1'b1, acc);
      if (obs !== exp_vec()) begin
         bad++;
         $display("FAIL flush_empty got=%h exp=%h", obs, exp_vec());
      end
      total++;
      step(1'b1, 32'h0000_0213, 32'h8000_0100, 1'b1, 1'b0, acc);
      if (obs !== exp_vec()) begin
         bad++;
         $display("FAIL flush_target got=%h exp=%h", obs, exp_vec());
      end
      total++;
   endtask

   task automatic test_illegal();
      logic acc;
      logic [31:0] ins [4] = '{32'h0000_0000, 32'h0000_0013, 32'h0000_0013, 32'h0000_0002};
      logic [31:0] ads [4] = '{32'h8000_0000, 32'h8000_0002, 32'h8000_0004, 32'h8000_0009};
      do_reset();
      for (int k = 0; k < 5; k++) begin
         step(k < 4, ins[k % 4], ads[k % 4], 1'b1, 1'b0, acc);
         if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL illegal k=%0d got=%h exp=%h", k, obs, exp_vec());
         end
         total++;
      end
   endtask

   task automatic test_wrap();
      logic acc;
      do_reset();
      for (int k = 0; k < 18; k++) begin
         step(k < 17, 32'h0000_0013, 32'h8000_0200 + 32'(4 * k), 1'b1, 1'b0, acc);
      end
      if (xfer_cnt_o !== CW'(1)) begin
         bad++;
         $display("FAIL wrap cnt=%0d exp=1", xfer_cnt_o);
      end
      total++;
   endtask

   task automatic test_random();
      logic        acc;
      logic [31:0] ins;
      logic [31:0] ad;
      logic        vi;
      do_reset();
      ins = $urandom();
      ad  = $urandom() & 32'hFFFF_FFFC;
      vi  = 1'b0;
      for (int k = 0; k < 400; k++) begin
         // a withdrawn or accepted word is replaced by a fresh one
         if (!vi || acc) begin
            ins = $urandom();
            if ($urandom_range(0, 3) != 0) ins[1:0] = 2'b11;
            ad = $urandom();
            if ($urandom_range(0, 3) != 0) ad[1:0] = 2'b00;
         end
         vi = ($urandom_range(0, 3) != 0);
         step(vi, ins, ad, ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0), acc);
         if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL random k=%0d got=%h exp=%h", k, obs, exp_vec());
         end
         total++;
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_illegal();
      test_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
